palette_ram_bank: RTL

PALETTE_RAM_BANK -- requirements
Module: palette_ram_bank

---
 rtl/palette_ram_bank.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/palette_ram_bank.sv
// Banked colour palette with a power-on default fill, a two-stage lookup
// pipeline and a global brightness fade applied to every lookup result.
//
// Lookup handshake: rd_en carries no ready; the pipeline never stalls, and
// every request accepted outside INIT returns exactly two cycles later as a
// single-cycle rd_valid with its colour and transparency flag.
module palette_ram_bank #(
    parameter int IDX_W      = 4,
    parameter int BANKS      = 4,
    parameter int COMP_W     = 4,
    parameter int TRANSP_IDX = 0,
    parameter int FADE_DIV   = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    output logic                       init_busy,
    input  logic                       wr_en,
    input  logic [$clog2(BANKS)-1:0]   wr_bank,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [3*COMP_W-1:0]        wr_rgb,
    input  logic                       rd_en,
    input  logic [$clog2(BANKS)-1:0]   rd_bank,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic                       rd_valid,
    output logic [COMP_W-1:0]          red,
    output logic [COMP_W-1:0]          green,
    output logic [COMP_W-1:0]          blue,
    output logic                       transparent,
    input  logic                       fade_start,
    input  logic                       fade_dir,
    output logic                       fade_done,
    output logic [1:0]                 dbg_state_o
);

    localparam int BANK_W = $clog2(BANKS);
    localparam int ADDR_W = BANK_W + IDX_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int RGB_W  = 3 * COMP_W;
    localparam int DIV_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [COMP_W-1:0] MAXC     = {COMP_W{1'b1}};
    localparam logic [COMP_W-1:0] ZEROC    = {COMP_W{1'b0}};
    localparam logic [RGB_W-1:0]  DEF_RED  = {MAXC, ZEROC, ZEROC};
    localparam logic [RGB_W-1:0]  DEF_GRN  = {ZEROC, MAXC, ZEROC};
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(FADE_DIV - 1);
    // The fade_start cycle itself counts toward the first divider period.
    localparam logic [DIV_W-1:0]  DIV_LOAD = (FADE_DIV > 1) ? DIV_W'(1) : '0;

    // Encoding is visible on dbg_state_o: 0=INIT, 1=RUN, 2=FADE.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_FADE = 2'd2
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic [COMP_W-1:0]   level_q;
    logic [COMP_W-1:0]   target_q;
    logic [DIV_W-1:0]    div_q;
    logic                fade_done_q;

    logic [RGB_W-1:0]    mem_q [DEPTH];

    logic                s1_valid_q;
    logic                s1_transp_q;
    logic [RGB_W-1:0]    s1_rgb_q;

    logic                rd_valid_q;
    logic                transparent_q;
    logic [COMP_W-1:0]   red_q;
    logic [COMP_W-1:0]   green_q;
    logic [COMP_W-1:0]   blue_q;

    logic                in_init;
    logic [COMP_W-1:0]   fade_tgt;
    logic [COMP_W-1:0]   level_step;
    logic [COMP_W-1:0]   dim;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [RGB_W-1:0]    mem_wdata;
    logic [ADDR_W-1:0]   rd_addr;

    // Subtract the dimming amount from one component, clamping at black.
    function automatic logic [COMP_W-1:0] fade_comp(input logic [COMP_W-1:0] c,
                                                    input logic [COMP_W-1:0] d);
        return (c > d) ? (c - d) : '0;
    endfunction

    assign in_init    = (state_q == ST_INIT);
    assign fade_tgt   = fade_dir ? MAXC : '0;
    assign level_step = (target_q > level_q) ? (level_q + COMP_W'(1))
                                             : (level_q - COMP_W'(1));
    assign dim        = MAXC - level_q;
    assign rd_addr    = {rd_bank, rd_idx};

    // Write-port mux: the default fill owns the RAM during INIT.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!Reset) begin
            if (in_init) begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt_q;
                mem_wdata = (init_cnt_q[IDX_W-1:0] == IDX_W'(1)) ? DEF_RED : DEF_GRN;
            end else if (wr_en) begin
                mem_we    = 1'b1;
                mem_waddr = {wr_bank, wr_idx};
                mem_wdata = wr_rgb;
            end
        end
    end

    // Control FSM: default fill, idle run, and fade stepping toward a target.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            level_q     <= MAXC;
            target_q    <= MAXC;
            div_q       <= '0;
            fade_done_q <= 1'b0;
        end else begin
            fade_done_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == CNT_LAST) begin
                        state_q <= ST_RUN;
                    end else begin
                        init_cnt_q <= init_cnt_q + ADDR_W'(1);
                    end
                end
                ST_RUN, ST_FADE: begin
                    if (fade_start) begin
                        // A new request retargets from the present level; no step this edge.
                        target_q <= fade_tgt;
                        div_q    <= DIV_LOAD;
                        if (fade_tgt == level_q) begin
                            fade_done_q <= 1'b1;
                            state_q     <= ST_RUN;
                        end else begin
                            state_q <= ST_FADE;
                        end
                    end else if (state_q == ST_FADE) begin
                        if (div_q == DIV_LAST) begin
                            div_q   <= '0;
                            level_q <= level_step;
                            if (level_step == target_q) begin
                                fade_done_q <= 1'b1;
                                state_q     <= ST_RUN;
                            end
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Palette storage; no reset because INIT rewrites every entry.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Lookup stage 1: registered RAM read, which returns pre-write data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_transp_q <= 1'b0;
        end else begin
            s1_valid_q  <= rd_en && !in_init;
            s1_transp_q <= (rd_idx == IDX_W'(TRANSP_IDX));
        end
        s1_rgb_q <= mem_q[rd_addr];
    end

    // Lookup stage 2: apply the current fade level and register the outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_valid_q    <= 1'b0;
            transparent_q <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            rd_valid_q    <= s1_valid_q;
            transparent_q <= s1_valid_q && s1_transp_q;
            red_q         <= fade_comp(s1_rgb_q[3*COMP_W-1:2*COMP_W], dim);
            green_q       <= fade_comp(s1_rgb_q[2*COMP_W-1:COMP_W], dim);
            blue_q        <= fade_comp(s1_rgb_q[COMP_W-1:0], dim);
        end
    end

    assign init_busy   = in_init;
    assign fade_done   = fade_done_q;
    assign rd_valid    = rd_valid_q;
    assign transparent = transparent_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign dbg_state_o = state_q;

endmodule
